// File: rtl/svga_timing_pkg.sv
// Shared SVGA 800x600@72 raster constants. The pixel/sprite pipeline imports
// the same bounds so its visible-area tests agree with the sync generator.
package svga_timing_pkg;
    localparam int H_VISIBLE   = 800;
    localparam int H_FRONT     = 56;
    localparam int H_SYNC      = 120;
    localparam int H_BACK      = 64;
    localparam int V_VISIBLE   = 600;
    localparam int V_FRONT     = 37;
    localparam int V_SYNC      = 6;
    localparam int V_BACK      = 23;
    localparam int SYNC_ACTIVE = 1;

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int H_W = 11;
    localparam int V_W = 10;
endpackage

// File: rtl/svga_sync_if.sv
// Raster output bundle: sync pulses, visible qualifier and pixel coordinates.
interface svga_sync_if;
    import svga_timing_pkg::*;

    logic           hsync;
    logic           vsync;
    logic           video_enable;
    logic [H_W-1:0] pixel_x;
    logic [V_W-1:0] pixel_y;

    modport master (output hsync, vsync, video_enable, pixel_x, pixel_y);
    modport slave  (input  hsync, vsync, video_enable, pixel_x, pixel_y);
endinterface

// File: rtl/sync_axis_counter.sv
// One raster axis: wrapping position counter plus sync/visible flags of the
// *next* position, so the parent can register them in step with the count.
module sync_axis_counter #(
    parameter int VISIBLE = 800,
    parameter int FRONT   = 56,
    parameter int SYNC    = 120,
    parameter int BACK    = 64,
    parameter int W       = 11
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         wrap_o,
    output logic         sync_nxt_o,
    output logic         vis_nxt_o
);
    localparam int           TOTAL   = VISIBLE + FRONT + SYNC + BACK;
    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    localparam logic [W-1:0] SYNC_LO = W'(VISIBLE + FRONT);
    localparam logic [W-1:0] SYNC_HI = W'(VISIBLE + FRONT + SYNC);
    localparam logic [W-1:0] VIS_END = W'(VISIBLE);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        wrap_o  = en_i && (count_q == LAST);
        count_d = count_q;
        if (en_i)
            count_d = wrap_o ? '0 : count_q + 1'b1;
        sync_nxt_o = (count_d >= SYNC_LO) && (count_d < SYNC_HI);
        vis_nxt_o  = (count_d < VIS_END);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count_o = count_q;
endmodule

// File: rtl/svga_sync.sv
// SVGA raster timing generator, one pixel per clock. Sync and video_enable are
// registered from next-state counts so they line up with pixel_x/pixel_y.
module svga_sync #(
    parameter int H_VISIBLE   = svga_timing_pkg::H_VISIBLE,
    parameter int H_FRONT     = svga_timing_pkg::H_FRONT,
    parameter int H_SYNC      = svga_timing_pkg::H_SYNC,
    parameter int H_BACK      = svga_timing_pkg::H_BACK,
    parameter int V_VISIBLE   = svga_timing_pkg::V_VISIBLE,
    parameter int V_FRONT     = svga_timing_pkg::V_FRONT,
    parameter int V_SYNC      = svga_timing_pkg::V_SYNC,
    parameter int V_BACK      = svga_timing_pkg::V_BACK,
    parameter int SYNC_ACTIVE = svga_timing_pkg::SYNC_ACTIVE
) (
    input  logic        clock,
    input  logic        reset,
    svga_sync_if.master vga_o
);
    localparam int   H_W = svga_timing_pkg::H_W;
    localparam int   V_W = svga_timing_pkg::V_W;
    localparam logic ACT = (SYNC_ACTIVE != 0);

    logic [H_W-1:0] h_count;
    logic [V_W-1:0] v_count;
    logic           h_wrap, h_sync_nxt, h_vis_nxt;
    logic           v_wrap_unused, v_sync_nxt, v_vis_nxt;
    logic           hsync_q, vsync_q, ven_q;
    logic           hsync_d, vsync_d, ven_d;

    sync_axis_counter #(
        .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .W(H_W)
    ) u_h (
        .clock(clock), .reset(reset), .en_i(1'b1),
        .count_o(h_count), .wrap_o(h_wrap),
        .sync_nxt_o(h_sync_nxt), .vis_nxt_o(h_vis_nxt)
    );

    // Lines advance only on the end-of-line wrap; frame wrap needs no consumer.
    sync_axis_counter #(
        .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .W(V_W)
    ) u_v (
        .clock(clock), .reset(reset), .en_i(h_wrap),
        .count_o(v_count), .wrap_o(v_wrap_unused),
        .sync_nxt_o(v_sync_nxt), .vis_nxt_o(v_vis_nxt)
    );

    always_comb begin
        hsync_d = h_sync_nxt ? ACT : ~ACT;
        vsync_d = v_sync_nxt ? ACT : ~ACT;
        ven_d   = h_vis_nxt && v_vis_nxt;
    end

    // (0,0) is visible, so video_enable resets high.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hsync_q <= ~ACT;
            vsync_q <= ~ACT;
            ven_q   <= 1'b1;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            ven_q   <= ven_d;
        end
    end

    assign vga_o.hsync        = hsync_q;
    assign vga_o.vsync        = vsync_q;
    assign vga_o.video_enable = ven_q;
    assign vga_o.pixel_x      = h_count;
    assign vga_o.pixel_y      = v_count;
endmodule

// File: tb/tb_svga_sync.sv
// Randomized reset/run bench: three svga_sync instances (full SVGA, a small
// active-high raster, a small active-low raster) against a cycle-count model.
module tb_svga_sync;
    typedef struct {
        int x, y;
        int hs, vs, ve;
    } exp_t;

    logic  clock = 1'b0;
    logic  reset = 1'b0;
    int    t;
    int    n_tests = 0;
    int    n_fail  = 0;
    bit    mon_en  = 1'b0;

    svga_sync_if ifd ();
    svga_sync_if ifa ();
    svga_sync_if ifb ();

    svga_sync dut_d (.clock(clock), .reset(reset), .vga_o(ifd));
    svga_sync #(.H_VISIBLE(40), .H_FRONT(4), .H_SYNC(8), .H_BACK(6),
                .V_VISIBLE(30), .V_FRONT(3), .V_SYNC(2), .V_BACK(4),
                .SYNC_ACTIVE(1))
        dut_a (.clock(clock), .reset(reset), .vga_o(ifa));
    svga_sync #(.H_VISIBLE(20), .H_FRONT(3), .H_SYNC(5), .H_BACK(4),
                .V_VISIBLE(10), .V_FRONT(2), .V_SYNC(3), .V_BACK(2),
                .SYNC_ACTIVE(0))
        dut_b (.clock(clock), .reset(reset), .vga_o(ifb));

    localparam int FA = 58 * 39;   // small-A frame length in clocks

    always #5 clock = ~clock;

    // Clocks elapsed since reset released; reset is async so it zeroes instantly.
    always @(posedge clock or negedge reset) begin
        if (!reset) t <= 0;
        else        t <= t + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (t=%0d)", tag, got, exp, t);
        end
    endtask

    // Position is just the clock count split into line/frame by division.
    function automatic exp_t model(input int tc, input int hv, input int hf, input int hsw,
                                   input int hb, input int vv, input int vf, input int vsw,
                                   input int vb, input int act);
        exp_t e;
        int ht, vt;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        e.x  = tc % ht;
        e.y  = (tc / ht) % vt;
        e.hs = (e.x >= hv + hf && e.x < hv + hf + hsw) ? act : 1 - act;
        e.vs = (e.y >= vv + vf && e.y < vv + vf + vsw) ? act : 1 - act;
        e.ve = (e.x < hv && e.y < vv) ? 1 : 0;
        return e;
    endfunction

    task automatic check_dut(input string n, input exp_t e, input int x, input int y,
                             input int hs, input int vs, input int ve);
        chk({n, ".x"},  x,  e.x);
        chk({n, ".y"},  y,  e.y);
        chk({n, ".hs"}, hs, e.hs);
        chk({n, ".vs"}, vs, e.vs);
        chk({n, ".ve"}, ve, e.ve);
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            check_dut("D", model(t, 800, 56, 120, 64, 600, 37, 6, 23, 1),
                      int'(ifd.pixel_x), int'(ifd.pixel_y), int'(ifd.hsync),
                      int'(ifd.vsync), int'(ifd.video_enable));
            check_dut("A", model(t, 40, 4, 8, 6, 30, 3, 2, 4, 1),
                      int'(ifa.pixel_x), int'(ifa.pixel_y), int'(ifa.hsync),
                      int'(ifa.vsync), int'(ifa.video_enable));
            check_dut("B", model(t, 20, 3, 5, 4, 10, 2, 3, 2, 0),
                      int'(ifb.pixel_x), int'(ifb.pixel_y), int'(ifb.hsync),
                      int'(ifb.vsync), int'(ifb.video_enable));
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, ".D.x"},  int'(ifd.pixel_x), 0);
        chk({tag, ".D.y"},  int'(ifd.pixel_y), 0);
        chk({tag, ".D.hs"}, int'(ifd.hsync), 0);
        chk({tag, ".D.vs"}, int'(ifd.vsync), 0);
        chk({tag, ".D.ve"}, int'(ifd.video_enable), 1);
        chk({tag, ".A.x"},  int'(ifa.pixel_x), 0);
        chk({tag, ".A.y"},  int'(ifa.pixel_y), 0);
        chk({tag, ".B.hs"}, int'(ifb.hsync), 1);
        chk({tag, ".B.vs"}, int'(ifb.vsync), 1);
        chk({tag, ".B.ve"}, int'(ifb.video_enable), 1);
    endtask

    task automatic release_and_check_first();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("rel.D.x", int'(ifd.pixel_x), 1);
        chk("rel.D.y", int'(ifd.pixel_y), 0);
        chk("rel.A.x", int'(ifa.pixel_x), 1);
    endtask

    initial begin
        int ve_cnt, hs_rise, hs_high, vs_rise, last_rise, prev_hs, prev_vs;
        reset = 1'b0;
        mon_en = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check_reset_vals("por");
        release_and_check_first();

        // Three whole small-A frames from the first visible pixel.
        ve_cnt = 0; hs_rise = 0; hs_high = 0; vs_rise = 0; last_rise = -1;
        prev_hs = 0; prev_vs = 0;
        for (int c = 1; c < 3 * FA; c++) begin
            @(negedge clock);
            if (c == 1) begin
                ve_cnt = 2;            // t=0 and t=1 were both visible
            end else begin
                ve_cnt += int'(ifa.video_enable);
            end
            hs_high += int'(ifa.hsync);
            if (ifa.hsync && prev_hs == 0) hs_rise++;
            if (ifa.vsync && prev_vs == 0) begin
                if (last_rise >= 0) chk("A.vs_period", t - last_rise, FA);
                last_rise = t;
                vs_rise++;
            end
            prev_hs = int'(ifa.hsync);
            prev_vs = int'(ifa.vsync);
        end
        chk("A.ve_per_3frames", ve_cnt, 3 * 40 * 30);
        chk("A.hs_pulses", hs_rise, 3 * 39);
        chk("A.hs_clocks", hs_high, 3 * 39 * 8);
        chk("A.vs_rises", vs_rise, 3);

        // Random run lengths with resets dropped between clock edges.
        for (int s = 0; s < 10; s++) begin
            repeat ($urandom_range(50, 3000)) @(negedge clock);
            #2;
            reset = 1'b0;
            #1;
            check_reset_vals("mid");
            repeat ($urandom_range(1, 4)) @(negedge clock);
            #1;
            check_reset_vals("hold");
            release_and_check_first();
        end

        repeat (20) @(negedge clock);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
